// File: rtl/tage_trace_sequencer.sv
// Trace-replay sequencer: fetches branch entries, drives TAGE predict/update handshakes, keeps hit statistics.
// Optional per-window statistics are enabled by defining TAGE_SEQ_WINDOW_STATS_EN.
module tage_trace_sequencer #(
    parameter int ADDRESS_SIZE           = 32,
    parameter int TRAINING_DATA_SIZE     = 4100000,
    parameter int INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
    parameter int WINDOW                 = 100000
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              Start,
    input  logic [INSTRUCTION_INDEX_SIZE-1:0] NumBranches,
    output logic [INSTRUCTION_INDEX_SIZE-1:0] TraceAddr,
    input  logic [ADDRESS_SIZE-1:0]           TracePC,
    input  logic                              TraceOutcome,
    output logic                              PredReq,
    output logic [ADDRESS_SIZE-1:0]           PredPC,
    input  logic                              PredAck,
    input  logic                              PredTaken,
    output logic                              UpdReq,
    output logic                              UpdTaken,
    input  logic                              UpdAck,
    output logic [INSTRUCTION_INDEX_SIZE-1:0] CorrectlyPredicted,
    output logic [INSTRUCTION_INDEX_SIZE-1:0] TotalBranches,
    output logic [INSTRUCTION_INDEX_SIZE-1:0] WindowCorrect,
    output logic                              WindowValid,
    output logic                              Busy,
    output logic                              Done
);

    localparam int IW = INSTRUCTION_INDEX_SIZE;
    localparam logic [IW-1:0] MAX_ENTRIES = IW'(TRAINING_DATA_SIZE);

    if (WINDOW < 1) begin : gBadWindow
        $error("tage_trace_sequencer: WINDOW must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        PREDICT,
        UPDATE,
        DONE
    } seqState_t;

    seqState_t state, nextState;

    logic [IW-1:0]           index;
    logic [IW-1:0]           indexNext;
    logic [IW-1:0]           numReg;
    logic [IW-1:0]           clampedNum;
    logic [IW-1:0]           totalReg;
    logic [IW-1:0]           correctReg;
    logic [ADDRESS_SIZE-1:0] pcReg;
    logic                    outcomeReg;
    logic                    hitReg;
    logic                    startNow;
    logic                    predFire;
    logic                    updFire;

    assign clampedNum = (NumBranches > MAX_ENTRIES) ? MAX_ENTRIES : NumBranches;
    assign indexNext  = index + IW'(1);
    assign startNow   = Start && ((state == IDLE) || (state == DONE));
    assign predFire   = (state == PREDICT) && PredAck;
    assign updFire    = (state == UPDATE) && UpdAck;

    assign TraceAddr          = index;
    assign PredPC             = pcReg;
    assign UpdTaken           = outcomeReg;
    assign TotalBranches      = totalReg;
    assign CorrectlyPredicted = correctReg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        PredReq   = 1'b0;
        UpdReq    = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                Busy = 1'b0;
                Done = (state == DONE);
                if (Start) begin
                    nextState = (clampedNum == '0) ? DONE : FETCH;
                end
            end
            FETCH:    nextState = WAIT_MEM;
            WAIT_MEM: nextState = PREDICT;
            PREDICT: begin
                PredReq = 1'b1;
                if (PredAck) begin
                    nextState = UPDATE;
                end
            end
            UPDATE: begin
                UpdReq = 1'b1;
                if (UpdAck) begin
                    nextState = (indexNext == numReg) ? DONE : FETCH;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Trace data arrives one cycle after the address, so it is captured while waiting in WAIT_MEM.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            index      <= '0;
            numReg     <= '0;
            totalReg   <= '0;
            correctReg <= '0;
            pcReg      <= '0;
            outcomeReg <= 1'b0;
            hitReg     <= 1'b0;
        end else begin
            if (startNow) begin
                numReg     <= clampedNum;
                index      <= '0;
                totalReg   <= '0;
                correctReg <= '0;
            end
            if (state == WAIT_MEM) begin
                pcReg      <= TracePC;
                outcomeReg <= TraceOutcome;
            end
            if (predFire) begin
                hitReg <= (PredTaken == outcomeReg);
            end
            if (updFire) begin
                totalReg   <= totalReg + IW'(1);
                correctReg <= correctReg + IW'(hitReg);
                index      <= indexNext;
            end
        end
    end

`ifdef TAGE_SEQ_WINDOW_STATS_EN
    localparam logic [IW-1:0] WINDOW_LAST = IW'(WINDOW - 1);

    logic [IW-1:0] winCount;
    logic [IW-1:0] winPos;
    logic [IW-1:0] winCorrectReg;
    logic          winValidReg;

    assign WindowCorrect = winCorrectReg;
    assign WindowValid   = winValidReg;

    // winPos tracks the position inside the current window, avoiding a modulo on TotalBranches.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            winCount      <= '0;
            winPos        <= '0;
            winCorrectReg <= '0;
            winValidReg   <= 1'b0;
        end else begin
            winValidReg <= 1'b0;
            if (startNow) begin
                winCount      <= '0;
                winPos        <= '0;
                winCorrectReg <= '0;
            end else if (updFire) begin
                if (winPos == WINDOW_LAST) begin
                    winCorrectReg <= winCount + IW'(hitReg);
                    winValidReg   <= 1'b1;
                    winCount      <= '0;
                    winPos        <= '0;
                end else begin
                    winCount <= winCount + IW'(hitReg);
                    winPos   <= winPos + IW'(1);
                end
            end
        end
    end
`else
    assign WindowCorrect = '0;
    assign WindowValid   = 1'b0;
`endif

endmodule

// File: tb/tb_tage_trace_sequencer.sv
// Self-checking bench for tage_trace_sequencer: table of replay runs plus reset-abort sequence.
// Window expectations follow TAGE_SEQ_WINDOW_STATS_EN as defined for the build.
module tb_tage_trace_sequencer;

    localparam int AW     = 32;
    localparam int TDS    = 20;
    localparam int IW     = $clog2(TDS);
    localparam int WIN    = 4;
    localparam int BUDGET = 400;

    logic          Clk;
    logic          Rst;
    logic          Start;
    logic [IW-1:0] NumBranches;
    logic [IW-1:0] TraceAddr;
    logic [AW-1:0] TracePC;
    logic          TraceOutcome;
    logic          PredReq;
    logic [AW-1:0] PredPC;
    logic          PredAck;
    logic          PredTaken;
    logic          UpdReq;
    logic          UpdTaken;
    logic          UpdAck;
    logic [IW-1:0] CorrectlyPredicted;
    logic [IW-1:0] TotalBranches;
    logic [IW-1:0] WindowCorrect;
    logic          WindowValid;
    logic          Busy;
    logic          Done;

    logic [AW-1:0] memPC  [0:31];
    logic          memOut [0:31];

    int   predDelay;
    int   updDelay;
    int   predCnt;
    int   updCnt;
    logic predInv;
    int   errors;
    int   checks;
    int   pulses;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          outcome;
    } ExpRec;

    typedef struct {
        int num;
        int predD;
        int updD;
        int inv;
        int expCycles;
        int expTotal;
        int expCorrect;
        int expPulses;
        int expLast;
    } CaseRec;

    ExpRec  expQ[$];
    CaseRec cases[7];
    CaseRec restartCase;

    tage_trace_sequencer #(
        .ADDRESS_SIZE      (AW),
        .TRAINING_DATA_SIZE(TDS),
        .WINDOW            (WIN)
    ) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Start             (Start),
        .NumBranches       (NumBranches),
        .TraceAddr         (TraceAddr),
        .TracePC           (TracePC),
        .TraceOutcome      (TraceOutcome),
        .PredReq           (PredReq),
        .PredPC            (PredPC),
        .PredAck           (PredAck),
        .PredTaken         (PredTaken),
        .UpdReq            (UpdReq),
        .UpdTaken          (UpdTaken),
        .UpdAck            (UpdAck),
        .CorrectlyPredicted(CorrectlyPredicted),
        .TotalBranches     (TotalBranches),
        .WindowCorrect     (WindowCorrect),
        .WindowValid       (WindowValid),
        .Busy              (Busy),
        .Done              (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous trace memory with one-cycle read latency.
    always @(posedge Clk) begin
        TracePC      <= memPC[TraceAddr];
        TraceOutcome <= memOut[TraceAddr];
    end

    // Predictor/updater models acknowledge after a programmable number of waiting cycles.
    always @(posedge Clk) begin
        if (PredReq && !PredAck) predCnt <= predCnt + 1;
        else                     predCnt <= 0;
        if (UpdReq && !UpdAck)   updCnt <= updCnt + 1;
        else                     updCnt <= 0;
    end

    assign PredAck   = PredReq && (predCnt == predDelay);
    assign UpdAck    = UpdReq && (updCnt == updDelay);
    assign PredTaken = ~predInv;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic noteMissing(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got request expected none (scoreboard empty)", name);
    endtask

    task automatic monitorCycle();
        if (PredReq) begin
            if (expQ.size() == 0) noteMissing("predReqUnexpected");
            else checkOutput("predPC", 64'(PredPC), 64'(expQ[0].pc));
        end
        if (UpdReq) begin
            if (expQ.size() == 0) begin
                noteMissing("updReqUnexpected");
            end else begin
                checkOutput("updTaken", 64'(UpdTaken), 64'(expQ[0].outcome));
                if (UpdAck) void'(expQ.pop_front());
            end
        end
        if (WindowValid) pulses++;
    endtask

    task automatic applyStimulus(input CaseRec r);
        int eff;
        int cycles;
        int expPulses;
        int expLast;
        eff       = (r.num > TDS) ? TDS : r.num;
        predDelay = r.predD;
        updDelay  = r.updD;
        predInv   = (r.inv != 0);
        pulses    = 0;
        for (int i = 0; i < eff; i++) expQ.push_back('{pc: memPC[i], outcome: memOut[i]});
        @(negedge Clk);
        NumBranches = IW'(r.num);
        Start       = 1'b1;
        @(posedge Clk);
        cycles = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge Clk);
            Start = 1'b0;
            monitorCycle();
            if (Done) begin
                cycles = i;
                break;
            end
        end
`ifdef TAGE_SEQ_WINDOW_STATS_EN
        expPulses = r.expPulses;
        expLast   = r.expLast;
`else
        expPulses = 0;
        expLast   = 0;
`endif
        checkOutput($sformatf("cycles[n=%0d]", r.num), 64'(cycles), 64'(r.expCycles));
        checkOutput($sformatf("total[n=%0d]", r.num), 64'(TotalBranches), 64'(r.expTotal));
        checkOutput($sformatf("correct[n=%0d]", r.num), 64'(CorrectlyPredicted), 64'(r.expCorrect));
        checkOutput($sformatf("busyEnd[n=%0d]", r.num), 64'(Busy), 64'(0));
        checkOutput($sformatf("pending[n=%0d]", r.num), 64'(expQ.size()), 64'(0));
        checkOutput($sformatf("winPulses[n=%0d]", r.num), 64'(pulses), 64'(expPulses));
        checkOutput($sformatf("winCorrect[n=%0d]", r.num), 64'(WindowCorrect), 64'(expLast));
        expQ.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".traceAddr"}, 64'(TraceAddr), 64'(0));
        checkOutput({tag, ".predReq"}, 64'(PredReq), 64'(0));
        checkOutput({tag, ".predPC"}, 64'(PredPC), 64'(0));
        checkOutput({tag, ".updReq"}, 64'(UpdReq), 64'(0));
        checkOutput({tag, ".updTaken"}, 64'(UpdTaken), 64'(0));
        checkOutput({tag, ".total"}, 64'(TotalBranches), 64'(0));
        checkOutput({tag, ".correct"}, 64'(CorrectlyPredicted), 64'(0));
        checkOutput({tag, ".winCorrect"}, 64'(WindowCorrect), 64'(0));
        checkOutput({tag, ".winValid"}, 64'(WindowValid), 64'(0));
        checkOutput({tag, ".busy"}, 64'(Busy), 64'(0));
        checkOutput({tag, ".done"}, 64'(Done), 64'(0));
    endtask

    initial begin
        logic [9:0] firstTen;
        bit         found;
        errors      = 0;
        checks      = 0;
        pulses      = 0;
        Rst         = 1'b0;
        Start       = 1'b0;
        NumBranches = '0;
        predDelay   = 0;
        updDelay    = 0;
        predInv     = 1'b0;

        // Outcomes 0..9: 1,1,0,1,0,0,1,1,1,1; later entries taken when index divisible by 3.
        firstTen = 10'b1111001011;
        for (int i = 0; i < 32; i++) begin
            memPC[i]  = 32'h0040_1000 + 32'(i) * 32'd12;
            memOut[i] = (i < 10) ? firstTen[i] : ((i % 3) == 0);
        end

        cases[0] = '{8, 0, 0, 0, 32, 8, 5, 2, 2};
        cases[1] = '{8, 3, 2, 0, 72, 8, 5, 2, 2};
        cases[2] = '{10, 0, 0, 0, 40, 10, 7, 2, 2};
        cases[3] = '{10, 1, 0, 1, 50, 10, 3, 2, 2};
        cases[4] = '{25, 0, 1, 0, 100, 20, 10, 5, 1};
        cases[5] = '{0, 2, 2, 0, 0, 0, 0, 0, 0};
        cases[6] = '{1, 2, 0, 1, 6, 1, 0, 0, 0};
        restartCase = '{2, 0, 0, 0, 8, 2, 2, 0, 0};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkResetValues("reset");
        Rst = 1'b1;

        for (int c = 0; c < 7; c++) applyStimulus(cases[c]);

        // Abort in PREDICT on the branch at index 3, then restart cleanly.
        predDelay = 2;
        updDelay  = 0;
        predInv   = 1'b0;
        for (int i = 0; i < 8; i++) expQ.push_back('{pc: memPC[i], outcome: memOut[i]});
        @(negedge Clk);
        NumBranches = IW'(8);
        Start       = 1'b1;
        @(posedge Clk);
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (PredReq && (TraceAddr == IW'(3))) begin
                found = 1'b1;
                break;
            end
            monitorCycle();
        end
        checkOutput("abortReached", 64'(found), 64'(1));
        Rst = 1'b0;
        #1;
        checkResetValues("abort");
        expQ.delete();
        @(negedge Clk);
        Rst = 1'b1;
        applyStimulus(restartCase);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tage_trace_sequencer.md
# tage_trace_sequencer

Trace-replay controller that drives the TAGE predictor top level from a branch-trace memory. Per trace entry it reads the branch PC and resolved outcome, issues a predict request, compares the returned prediction, then issues an update with the true outcome. It keeps running hit statistics and per-window hit counts, replacing free-running bench-side bookkeeping with a synthesizable, handshaked sequencer.

## Interface
- ADDRESS_SIZE, 32, branch PC width
- TRAINING_DATA_SIZE, 4100000, maximum trace entries
- INSTRUCTION_INDEX_SIZE, $clog2(TRAINING_DATA_SIZE), trace index and counter width
- WINDOW, 100000, branches per statistics window

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  level; sampled in IDLE and DONE
- NumBranches  in  INSTRUCTION_INDEX_SIZE  entries to replay; latched on Start
- TraceAddr  out  INSTRUCTION_INDEX_SIZE  trace memory read index
- TracePC  in  ADDRESS_SIZE  trace memory PC; valid 1 cycle after TraceAddr
- TraceOutcome  in  1  trace memory taken bit; same timing as TracePC
- PredReq  out  1  prediction request
- PredPC  out  ADDRESS_SIZE  PC under prediction
- PredAck  in  1  prediction valid this cycle
- PredTaken  in  1  predicted direction, valid with PredAck
- UpdReq  out  1  update request
- UpdTaken  out  1  resolved direction for update
- UpdAck  in  1  update accepted this cycle
- CorrectlyPredicted  out  INSTRUCTION_INDEX_SIZE  running correct count
- TotalBranches  out  INSTRUCTION_INDEX_SIZE  running branch count
- WindowCorrect  out  INSTRUCTION_INDEX_SIZE  correct count of last completed window
- WindowValid  out  1  one-cycle pulse when WindowCorrect updates
- Busy  out  1  high in any state except IDLE and DONE
- Done  out  1  high in DONE

## Operation
- States: IDLE, FETCH, WAIT_MEM, PREDICT, UPDATE, DONE.
- IDLE: Start=1 latches NumBranches (clamped to TRAINING_DATA_SIZE), clears index and all counters. It goes to FETCH, or to DONE if NumBranches=0.
- FETCH: TraceAddr=index. Next state is WAIT_MEM.
- WAIT_MEM: latches TracePC and TraceOutcome. Next state is PREDICT.
- PREDICT: PredReq=1 and PredPC held stable until PredAck=1 is sampled. On PredAck it latches hit=(PredTaken==outcome) and moves to UPDATE. PredReq deasserts the following cycle.
- UPDATE: UpdReq=1 and UpdTaken=outcome held until UpdAck=1. On UpdAck:
  - TotalBranches+1, CorrectlyPredicted+hit, window counter updated, index+1.
  - Next state is DONE if index+1==NumBranches, else FETCH.
- DONE: Done=1 and counters held. Start=1 restarts exactly as from IDLE.
- Ack inputs are ignored outside the matching state. An ack arriving in the same cycle the request first asserts is accepted.
- Counters are unsigned, INSTRUCTION_INDEX_SIZE bits. The clamp guarantees they never wrap.

## Timing
- Reset (Rst=0, asynchronous):
  - State is IDLE.
  - TraceAddr=0, PredReq=0, PredPC=0, UpdReq=0, UpdTaken=0.
  - All counters=0, WindowValid=0, Busy=0, Done=0.
- Reset asserted mid-operation aborts immediately. Any outstanding request drops with no further counter update.
- Minimum 4 cycles per branch: FETCH, WAIT_MEM, PREDICT with same-cycle ack, UPDATE with same-cycle ack.
- Trace memory is synchronous with exactly 1-cycle read latency.
- Counter outputs are registered and change on the edge that leaves UPDATE.
- Done rises 1 cycle after the final UpdAck.

## Configuration
- TAGE_SEQ_WINDOW_STATS_EN defined:
  - A window counter tracks correct predictions since the last window boundary.
  - When TotalBranches reaches a nonzero multiple of WINDOW, WindowCorrect takes the window count including the current branch, WindowValid pulses for 1 cycle, and the window counter clears.
  - A partial final window is not reported.
- Not defined: WindowCorrect=0 and WindowValid=0 constantly, and no window logic is instantiated.

## Test plan
- NumBranches=8, predictor model always acks same cycle and predicts taken, trace has 5 taken -> Done after 32 cycles, TotalBranches=8, CorrectlyPredicted=5.
- PredAck delayed 3 cycles and UpdAck delayed 2 cycles -> PredReq/PredPC and UpdReq/UpdTaken held stable throughout, counts unchanged from the same-cycle case.
- WINDOW=4, macro defined, NumBranches=10 with hits 1,1,0,1 / 0,0,1,1 / 1,1 -> WindowValid pulses twice with WindowCorrect=3 then 2, with no pulse at Done.
- NumBranches=0 with Start -> PredReq never asserts, Done=1 on the cycle after Start, counters stay 0.
- Rst pulled low while in PREDICT on branch 3 -> all outputs return to reset values asynchronously. A subsequent Start with NumBranches=2 completes with TotalBranches=2.
- Macro undefined, WINDOW=4, NumBranches=8 -> WindowValid never asserts, WindowCorrect=0.
